// File: rtl/execute_mdu.sv
// Iterative RV64M multiply/divide unit: one bit per cycle, valid/ready in and out, flushable.
// Define EXECUTE_MDU_FAST_MUL_EN to compute multiplies with a single-cycle combinational product.
module execute_mdu #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src_a,
  input  logic [XLEN-1:0]  in_src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CntW   = $clog2(XLEN + 1);
  localparam int unsigned WShift = XLEN - 32;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StMulIter, StDivIter, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                word_q, word_d;
  logic [XLEN-1:0]     src_a_q, src_a_d, src_b_q, src_b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [XLEN-1:0]     d_q, d_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d, a_neg_q, a_neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  // Sign-correct a magnitude product and pick the requested half (W forms: low word).
  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic [31:0] p_lo,
                                               input logic neg, input logic word,
                                               input logic high);
    logic [2*XLEN-1:0] pf;
    logic [31:0]       lf;
    logic [XLEN-1:0]   r;
    pf = neg ? -p : p;
    lf = neg ? -p_lo : p_lo;
    if (word)      r = sext32(lf);
    else if (high) r = pf[2*XLEN-1:XLEN];
    else           r = pf[XLEN-1:0];
    return r;
  endfunction

  // Operand preparation on the latched request
  logic            sign_a, sign_b, a_neg, b_neg, is_div, is_rem, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, special_res, special_raw;

  always_comb begin
    sign_a = 1'b1;
    sign_b = 1'b1;
    case (op_q)
      3'd2:                 sign_b = 1'b0;
      3'd3, 3'd5, 3'd7: begin
        sign_a = 1'b0;
        sign_b = 1'b0;
      end
      default: ;
    endcase
    a_ext = word_q ? (sign_a ? sext32(src_a_q[31:0]) : XLEN'(src_a_q[31:0])) : src_a_q;
    b_ext = word_q ? (sign_b ? sext32(src_b_q[31:0]) : XLEN'(src_b_q[31:0])) : src_b_q;
    a_neg = sign_a & a_ext[XLEN-1];
    b_neg = sign_b & b_ext[XLEN-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;
    is_div = op_q[2];
    is_rem = op_q[2] & op_q[1];
    div_zero = word_q ? (src_b_q[31:0] == 32'd0) : (src_b_q == '0);
    div_ovf  = sign_a & (word_q ? (src_a_q[31:0] == 32'h8000_0000 && &src_b_q[31:0])
                                : (src_a_q == MinNeg && &src_b_q));
    if (div_zero) special_raw = is_rem ? a_ext : '1;
    else          special_raw = is_rem ? '0 : a_ext;
    special_res = word_q ? sext32(special_raw[31:0]) : special_raw;
  end

  // Shift-add step: acc = {partial sum, unconsumed multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
  assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient shift register}
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_acc;
  logic [XLEN-1:0]   div_q, div_r, div_res;
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, d_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_acc  = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  assign div_q    = neg_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
  assign div_r    = a_neg_q ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];
  assign div_res  = is_rem ? div_r : div_q;

`ifdef EXECUTE_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`endif

  assign in_ready   = (state_q == StIdle) && !flush;
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_tag    = tag_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    tag_d    = tag_q;
    d_d      = d_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          op_d    = in_op;
          word_d  = in_word;
          src_a_d = in_src_a;
          src_b_d = in_src_b;
          tag_d   = in_tag;
          state_d = StPrep;
        end
      end
      StPrep: begin
        d_d     = is_div ? b_abs : a_abs;
        acc_d   = {{XLEN{1'b0}}, is_div ? (word_q ? a_abs << WShift : a_abs) : b_abs};
        cnt_d   = word_q ? CntW'(32) : CntW'(XLEN);
        neg_d   = a_neg ^ b_neg;
        a_neg_d = a_neg;
        if (is_div) begin
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d = StDivIter;
          end
        end else begin
`ifdef EXECUTE_MDU_FAST_MUL_EN
          result_d = mul_pick(fast_prod, fast_prod[31:0], a_neg ^ b_neg, word_q, op_q != 3'd0);
          state_d  = StDone;
`else
          state_d = StMulIter;
`endif
        end
      end
      StMulIter: begin
        acc_d = mul_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          // W products land XLEN-32 bits up since only 32 shifts occurred
          result_d = mul_pick(mul_acc, mul_acc[WShift +: 32], neg_q, word_q, op_q != 3'd0);
          state_d  = StDone;
        end
      end
      StDivIter: begin
        acc_d = div_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d = word_q ? sext32(div_res[31:0]) : div_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      word_q   <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      tag_q    <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      tag_q    <= tag_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// Directed, table-driven bench for execute_mdu with hand-written handshake, flush and reset cases.
module tb_execute_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_src_a = '0;
  logic [63:0] in_src_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  execute_mdu #(.XLEN(64), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_src_a   (in_src_a),
    .in_src_b   (in_src_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef EXECUTE_MDU_FAST_MUL_EN
  localparam int MulLat  = 2;
  localparam int MulWLat = 2;
`else
  localparam int MulLat  = 66;
  localparam int MulWLat = 34;
`endif

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer a request at a negedge; returns #1 after the acceptance edge.
  task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    in_op = op;
    in_word = word;
    in_src_a = a;
    in_src_b = b;
    in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid is seen; out_valid seen after edge N+c is cycle N+c+1.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  seen;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MulLat};
    vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFE, MulLat};
    vecs[2]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h4000_0000_0000_0000, MulLat};
    vecs[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[5]  = '{3'd4, 1'b1, 64'h1_0000_0014, 64'hFFFF_FFFF_FFFF_FFFC,
                 64'hFFFF_FFFF_FFFF_FFFB, 34};
    vecs[6]  = '{3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[7]  = '{3'd7, 1'b0, 64'd9, 64'd0, 64'd9, 2};
    vecs[8]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 2};
    vecs[9]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[10] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MulLat};
    vecs[11] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MulWLat};
    vecs[12] = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66};
    vecs[13] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66};
    vecs[14] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[15] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[16] = '{3'd3, 1'b1, 64'd3, 64'd5, 64'd15, MulWLat};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Vector table
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 5'(i + 1));
      wait_valid(cyc);
      check($sformatf("v%0d_latency", i), 64'(cyc + 1), 64'(vecs[i].lat));
      check($sformatf("v%0d_result", i), out_result, vecs[i].exp);
      check($sformatf("v%0d_tag", i), 64'(out_tag), 64'(i + 1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Request offered together with flush is refused
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = 3'd5;
    in_src_b = 64'd0;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_no_accept_busy", 64'(busy), 64'd0);

    // Flush mid-iteration
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("midflush_busy", 64'(busy), 64'd0);
    check("midflush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midflush_never_valid", 64'(seen), 64'd0);

    // Backpressure: result held stable, no new acceptance
    out_ready = 1'b0;
    issue(3'd7, 1'b0, 64'd9, 64'd0, 5'd3);
    wait_valid(cyc);
    check("hold_latency", 64'(cyc + 1), 64'd2);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_result", c), out_result, 64'd9);
      check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("hold_tag", 64'(out_tag), 64'd3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", 64'(out_valid), 64'd0);
    check("hold_release_in_ready", 64'(in_ready), 64'd1);

    // Reset pulse during divide iteration
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd21);
    repeat (20) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_result", out_result, 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_never_valid", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mdu.md
# execute_mdu

Parametrised multi-cycle multiply/divide unit in the execute stage, alongside the single-cycle ALU path. It takes the RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms), iterates one bit per cycle, and returns an XLEN-bit result tagged with the destination register. Valid/ready handshakes connect it to the pipeline: the decode side stalls on `in_ready=0`, and the memory side drains `out_*`. A flush input discards in-flight work on redirect.

## Interface
- `XLEN`, 64: operand/result width; must be even and ≥ 32.
- `TAG_W`, 5: destination tag width (register index).

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: abort current operation and drop any pending output.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: unit can accept this cycle.
- `in_op`, in, 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_word`, in, 1: W-form: use low 32 bits of operands; result is 32-bit, sign-extended to XLEN.
- `in_src_a`, in, XLEN: rs1 (dividend / multiplicand).
- `in_src_b`, in, XLEN: rs2 (divisor / multiplier).
- `in_tag`, in, TAG_W: destination register, returned unchanged.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer takes result.
- `out_result`, out, XLEN: result.
- `out_tag`, out, TAG_W: tag of result.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, PREP, MUL_ITER, DIV_ITER, DONE.
- IDLE: `in_ready = !flush`. On `in_valid && in_ready`, latch op/word/operands/tag and go to PREP.
- PREP, 1 cycle:
  - Compute operand signs.
  - Take absolute values for signed ops; unsigned for U variants. MULHSU: a signed, b unsigned.
  - For W forms, first sign-extend (signed ops) or zero-extend (unsigned ops) bit 31.
  - Load iteration counter K = `in_word` ? 32 : XLEN.
  - Go to MUL_ITER or DIV_ITER.
  - Exception: divide special cases go directly to DONE with a fixed result.
- MUL_ITER: shift-add, one multiplier bit per cycle, into a 2·K-bit accumulator. After K iterations, apply result sign negation, then go to DONE.
- DIV_ITER: restoring division, one quotient bit per cycle. After K iterations, apply sign fix, then go to DONE.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Result selection:
  - MUL: low K bits.
  - MULH/MULHSU/MULHU: high K bits.
  - W forms: result bits 31:0 sign-extended to XLEN. MULH* with `in_word` returns the MULW result.
- Divide special cases (decided in PREP, no iteration):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
  - All values are in K-bit width, then extended.
- DONE: `out_valid=1`. `out_result`/`out_tag` stay stable until `out_ready`. On `out_ready`, go to IDLE. There is no back-to-back accept in the DONE cycle.
- `flush` (any state): next state IDLE, `out_valid` low next cycle, latched work discarded. A request offered in the same cycle as `flush` is not accepted.
- Reset: state IDLE; `out_valid`=0, `out_result`=0, `out_tag`=0, `busy`=0, all internal registers 0. Asserting `rst_n` low mid-operation aborts immediately; no output is produced.

## Timing
- Acceptance edge = cycle N.
- Iterative ops: `out_valid` first high in cycle N+K+2.
  - XLEN=64: 66 cycles.
  - W-form: 34 cycles.
- Divide special cases: `out_valid` in cycle N+2.
- Next acceptance is possible at earliest the cycle after the `out_valid && out_ready` edge.
- `in_ready` is combinational from state and `flush` only. It never depends on `in_valid`.

## Configuration
- `EXECUTE_MDU_FAST_MUL_EN` defined:
  - All multiply ops compute with a single-cycle combinational XLEN×XLEN product in PREP and go directly to DONE.
  - `out_valid` at N+2.
  - Divide is unchanged.
- Macro undefined: iterative shift-add multiplier as described above.

## Test plan
- MUL, a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD), `out_ready`=1 → `out_result`=0xFFFF_FFFF_FFFF_FFEB, tag echoed; `out_valid` at N+66 (N+2 with the fast macro).
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
- MULH, a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000.
- DIV, a=−7, b=2 → −3. REM on the same operands → −1. Both at N+66.
- DIVW, a=0x1_0000_0014, b=−4 → 0xFFFF_FFFF_FFFF_FFFB at N+34.
- DIVU, b=0 → 0xFFFF_FFFF_FFFF_FFFF at N+2. REMU, a=9, b=0 → 9.
- DIV, 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000. REM on the same operands → 0.
- Hold `out_ready`=0 for 10 cycles → `out_result` stable and `in_ready`=0 throughout.
- Mid-iteration `flush` → IDLE next cycle, no `out_valid`.
- `rst_n` pulse during DIV_ITER → all outputs 0 immediately.
